// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: command/response sequencer in front of an 8-bit UART.
// Sends a CMD_BYTES command MSB-byte-first, then assembles a RESP_BYTES
// response MSB-byte-first, with a response watchdog of TO_CYCLES clocks.
// Optional build macro CMD_CHKSUM_EN appends an XOR checksum byte to the
// transmitted frame.
module uart_cmd_seq #(
    parameter int CMD_BYTES  = 2,
    parameter int RESP_BYTES = 1,
    parameter int TO_CYCLES  = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    send_cmd,
    input  logic [8*CMD_BYTES-1:0]  cmd,
    output logic                    busy,
    output logic                    cmd_sent,
    output logic                    resp_rdy,
    output logic [8*RESP_BYTES-1:0] resp,
    output logic                    timeout,
    output logic [7:0]              tx_data,
    output logic                    trmt,
    input  logic                    tx_done,
    input  logic [7:0]              rx_data,
    input  logic                    rx_rdy,
    output logic                    clr_rx_rdy
);

    localparam int CW = 8 * CMD_BYTES;
    localparam int RW = 8 * RESP_BYTES;
`ifdef CMD_CHKSUM_EN
    localparam int FRAME_BYTES = CMD_BYTES + 1;
`else
    localparam int FRAME_BYTES = CMD_BYTES;
`endif
    localparam int SW  = 8 * FRAME_BYTES;
    localparam int BCW = $clog2(FRAME_BYTES + 1);
    localparam int RCW = $clog2(RESP_BYTES + 1);
    // A zero-cycle timeout still needs a legal (1-bit) counter
    localparam int TOW = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_TX   = 2'd2,
        WAIT_RESP = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  sreg;
    logic [SW-1:0]  frame_load;
    logic [BCW-1:0] byte_cnt;
    logic [RCW-1:0] rcnt;
    logic [RW-1:0]  acc;
    logic [RW-1:0]  acc_nxt;
    logic [TOW-1:0] to_cnt;

    // FSM strobes
    logic accept;
    logic tx_next;
    logic tx_last;
    logic rx_take;
    logic rx_done;
    logic to_expire;

`ifdef CMD_CHKSUM_EN
    function automatic logic [7:0] cmd_xor(input logic [CW-1:0] c);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < CMD_BYTES; i++) begin
            x = x ^ c[8*i +: 8];
        end
        return x;
    endfunction

    assign frame_load = {cmd, cmd_xor(cmd)};
`else
    assign frame_load = cmd;
`endif

    // Next response accumulator value: new byte enters at the LSB end
    assign acc_nxt    = (acc << 8) | RW'(rx_data);

    assign tx_data    = sreg[SW-1 -: 8];
    assign trmt       = (state_q == SEND);
    // Every received byte is consumed, whether used or discarded
    assign clr_rx_rdy = rx_rdy;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and datapath strobes
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        tx_next   = 1'b0;
        tx_last   = 1'b0;
        rx_take   = 1'b0;
        rx_done   = 1'b0;
        to_expire = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_cmd) begin
                    accept  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (byte_cnt == BCW'(FRAME_BYTES - 1)) begin
                        tx_last = 1'b1;
                        state_d = WAIT_RESP;
                    end else begin
                        tx_next = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            WAIT_RESP: begin
                if (rx_rdy) begin
                    rx_take = 1'b1;
                    if (rcnt == RCW'(RESP_BYTES - 1)) begin
                        rx_done = 1'b1;
                        state_d = IDLE;
                    end
                end
                // A byte landing on the expiry cycle completes first
                if (!rx_done && (TO_CYCLES > 0) && (to_cnt == TOW'(1))) begin
                    to_expire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame shifter, counters, response capture and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg     <= '0;
            byte_cnt <= '0;
            rcnt     <= '0;
            acc      <= '0;
            to_cnt   <= '0;
            resp     <= '0;
            cmd_sent <= 1'b0;
            resp_rdy <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            if (accept) begin
                sreg     <= frame_load;
                byte_cnt <= '0;
                rcnt     <= '0;
                acc      <= '0;
                cmd_sent <= 1'b0;
                resp_rdy <= 1'b0;
                timeout  <= 1'b0;
            end
            if (tx_next) begin
                sreg     <= sreg << 8;
                byte_cnt <= byte_cnt + BCW'(1);
            end
            if (tx_last) begin
                cmd_sent <= 1'b1;
                to_cnt   <= TOW'(TO_CYCLES);
            end
            if ((state_q == WAIT_RESP) && (TO_CYCLES > 0) && (to_cnt != '0)) begin
                to_cnt <= to_cnt - TOW'(1);
            end
            if (rx_take) begin
                acc  <= acc_nxt;
                rcnt <= rcnt + RCW'(1);
            end
            if (rx_done) begin
                resp     <= acc_nxt;
                resp_rdy <= 1'b1;
            end
            if (to_expire) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
